mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/rr_pick2.sv | 13 +
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM handshake state, plus arbiter state and owner kind.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef enum logic {KIND_I, KIND_D} arb_kind_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: when both request, pick the one that was not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);

    always_comb begin
        if (req == 2'b11) pick = ~last;
        else              pick = req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-CPU arbiter for a single RAM: data before instruction, round-robin per class,
// data owners hold the RAM for a two-word block.
//
//  state | meaning
//  IDLE  | RAM undriven; arbitrate pending requests, register owner
//  GRANT | RAM driven from owner; wait released on ACCESS
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CPUS-1:0]     iREN,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  word_t [CPUS-1:0]    iaddr,
    input  word_t [CPUS-1:0]    daddr,
    input  word_t [CPUS-1:0]    dstore,
    output logic [CPUS-1:0]     iwait,
    output logic [CPUS-1:0]     dwait,
    output word_t [CPUS-1:0]    iload,
    output word_t [CPUS-1:0]    dload,
    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate
);

    arb_state_t state, state_n;
    arb_kind_t  owner_kind, owner_kind_n;
    logic       owner_cpu, owner_cpu_n;
    logic       beat, beat_n;
    logic       rr_d, rr_d_n;
    logic       rr_i, rr_i_n;

    logic [CPUS-1:0] dreq;
    logic            pick_d, pick_i;
    logic            owner_en;

    assign dreq = dREN | dWEN;

    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

    rr_pick2 u_pick_d (
        .req  (dreq),
        .last (rr_d),
        .pick (pick_d)
    );

    rr_pick2 u_pick_i (
        .req  (iREN),
        .last (rr_i),
        .pick (pick_i)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            owner_cpu  <= 1'b0;
            owner_kind <= KIND_I;
            beat       <= 1'b0;
            rr_d       <= 1'b1;
            rr_i       <= 1'b1;
        end else begin
            state      <= state_n;
            owner_cpu  <= owner_cpu_n;
            owner_kind <= owner_kind_n;
            beat       <= beat_n;
            rr_d       <= rr_d_n;
            rr_i       <= rr_i_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_cpu_n  = owner_cpu;
        owner_kind_n = owner_kind;
        beat_n       = beat;
        rr_d_n       = rr_d;
        rr_i_n       = rr_i;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = '1;
        dwait        = '1;
        owner_en     = (owner_kind == KIND_I) ? iREN[owner_cpu] : dreq[owner_cpu];

        if (state == IDLE) begin
            if (|dreq) begin
                state_n      = GRANT;
                owner_cpu_n  = pick_d;
                owner_kind_n = KIND_D;
                beat_n       = 1'b0;
            end else if (|iREN) begin
                state_n      = GRANT;
                owner_cpu_n  = pick_i;
                owner_kind_n = KIND_I;
                beat_n       = 1'b0;
            end
        end else begin
            // A dropped enable releases the RAM in the same cycle.
            if (owner_en) begin
                if (owner_kind == KIND_I) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[owner_cpu];
                end else if (dWEN[owner_cpu]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[owner_cpu];
                    ramstore = dstore[owner_cpu];
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[owner_cpu];
                end
            end

            if (ramstate == ACCESS) begin
                if (owner_kind == KIND_I) iwait[owner_cpu] = 1'b0;
                else                      dwait[owner_cpu] = 1'b0;
            end

            if (!owner_en) begin
                state_n = IDLE;
                beat_n  = 1'b0;
            end else if (ramstate == ACCESS) begin
                if (owner_kind == KIND_I) begin
                    state_n = IDLE;
                    rr_i_n  = owner_cpu;
                end else if (!beat) begin
                    beat_n = 1'b1;
                end else begin
                    state_n = IDLE;
                    beat_n  = 1'b0;
                    rr_d_n  = owner_cpu;
                end
            end
        end
    end

endmodule
